ex_stage: RTL and testbench

Execute stage of the five-stage pipeline. It consumes the ID/EX latch outputs and computes the ALU result, resolves BEQ/BNE/JR, and registers everything into the EX/MEM latch. Shifts (SLL/SRL) run on an iterative one-bit-per-cycle shifter that stalls the front end while busy. The block owns the EX/MEM register, so memory-stage stalls and flushes act here.

---
 rtl/ex_stage_if.sv | 55 +++++
 rtl/ex_stage.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_ex_stage.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_stage_if.sv
// ex_stage_if: bundles the ID/EX operand/control inputs, the stall/flush
// controls and the EX/MEM outputs of the execute stage.
// slave  = the execute stage itself, master = whoever drives ID/EX.
interface ex_stage_if #(
  parameter int WORD_W = 32
);
  // ID/EX side
  logic [WORD_W-1:0] instr_i;
  logic [WORD_W-1:0] npc_i;
  logic [WORD_W-1:0] rdat1_i;
  logic [WORD_W-1:0] rdat2_i;
  logic [3:0]        aluOp_i;
  logic              aluSrc_i;
  logic              shift_i;
  logic              jpSel_i;
  logic [1:0]        pcSrc_i;
  logic              regWr_i;
  logic              dWEN_i;
  logic              dREN_i;
  logic              halt_i;
  logic [2:0]        rdSel_i;
  // pipeline control
  logic              en;
  logic              flush;
  // hazard / redirect
  logic              busy;
  logic              br_taken;
  logic [WORD_W-1:0] br_target;
  // EX/MEM side
  logic [WORD_W-1:0] result_o;
  logic [WORD_W-1:0] wdat_o;
  logic [WORD_W-1:0] npc_o;
  logic [WORD_W-1:0] instr_o;
  logic              regWr_o;
  logic              dWEN_o;
  logic              dREN_o;
  logic              halt_o;
  logic [2:0]        rdSel_o;

  modport master (
    output instr_i, npc_i, rdat1_i, rdat2_i, aluOp_i, aluSrc_i, shift_i,
           jpSel_i, pcSrc_i, regWr_i, dWEN_i, dREN_i, halt_i, rdSel_i,
           en, flush,
    input  busy, br_taken, br_target, result_o, wdat_o, npc_o, instr_o,
           regWr_o, dWEN_o, dREN_o, halt_o, rdSel_o
  );

  modport slave (
    input  instr_i, npc_i, rdat1_i, rdat2_i, aluOp_i, aluSrc_i, shift_i,
           jpSel_i, pcSrc_i, regWr_i, dWEN_i, dREN_i, halt_i, rdSel_i,
           en, flush,
    output busy, br_taken, br_target, result_o, wdat_o, npc_o, instr_o,
           regWr_o, dWEN_o, dREN_o, halt_o, rdSel_o
  );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the five-stage pipeline.
// Computes the ALU result, resolves BEQ/BNE/JR and owns the EX/MEM latch.
// Build option: define EX_FAST_SHIFT_EN to replace the iterative
// one-bit-per-cycle shifter (which stalls the front end via busy) with a
// single-cycle barrel shifter.
package cpu_types_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;

  // I-type opcodes whose immediate is not sign-extended
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_XORI = 6'h0E;
  localparam logic [5:0] OP_LUI  = 6'h0F;
endpackage

module ex_stage
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic      CLK,
  input  logic      nRST,
  ex_stage_if.slave exif
);

  typedef struct packed {
    logic [WORD_W-1:0] result;
    logic [WORD_W-1:0] wdat;
    logic [WORD_W-1:0] npc;
    logic [WORD_W-1:0] instr;
    logic              regWr;
    logic              dWEN;
    logic              dREN;
    logic              halt;
    logic [2:0]        rdSel;
  } exMem_t;

  // instruction fields
  logic [5:0]        opcode;
  logic [15:0]       imm16;
  logic [4:0]        shamt;
  aluop_t            aluOp;
  logic              shiftLeft;

  logic [WORD_W-1:0] immSext;
  logic [WORD_W-1:0] immExt;
  logic [WORD_W-1:0] opA;
  logic [WORD_W-1:0] opB;
  logic [WORD_W-1:0] aluOut;
  logic [WORD_W-1:0] shiftOut;
  logic [WORD_W-1:0] resultS;
  logic [WORD_W-1:0] branchTgt;
  logic [WORD_W-1:0] brTargetS;
  logic              isZero;
  logic              takenRaw;
  logic              stallEx;
  logic              busyS;

  exMem_t            exMemN;
  exMem_t            exMemR;

  assign opcode    = exif.instr_i[31:26];
  assign imm16     = exif.instr_i[15:0];
  assign shamt     = exif.instr_i[10:6];
  assign aluOp     = aluop_t'(exif.aluOp_i);
  assign shiftLeft = (aluOp == ALU_SLL);

  assign immSext   = {{(WORD_W-16){imm16[15]}}, imm16};

  // Immediate extension depends on the opcode: logicals zero-extend, LUI shifts up
  always_comb begin
    immExt = immSext;
    case (opcode)
      OP_ANDI, OP_ORI, OP_XORI: immExt = {{(WORD_W-16){1'b0}}, imm16};
      OP_LUI:                   immExt = {imm16, {(WORD_W-16){1'b0}}};
      default:                  immExt = immSext;
    endcase
  end

  assign opA = exif.rdat1_i;
  assign opB = exif.aluSrc_i ? immExt : exif.rdat2_i;

  // ALU: arithmetic wraps, compares yield 0/1; shift codes go through the shifter path
  always_comb begin
    aluOut = {WORD_W{1'b0}};
    case (aluOp)
      ALU_ADD:  aluOut = opA + opB;
      ALU_SUB:  aluOut = opA - opB;
      ALU_AND:  aluOut = opA & opB;
      ALU_OR:   aluOut = opA | opB;
      ALU_XOR:  aluOut = opA ^ opB;
      ALU_NOR:  aluOut = ~(opA | opB);
      ALU_SLT:  aluOut = {{(WORD_W-1){1'b0}}, ($signed(opA) < $signed(opB))};
      ALU_SLTU: aluOut = {{(WORD_W-1){1'b0}}, (opA < opB)};
      default:  aluOut = {WORD_W{1'b0}};
    endcase
  end

  // ------------------------------------------------------------------
  // Shifter
  // ------------------------------------------------------------------
`ifdef EX_FAST_SHIFT_EN
  assign shiftOut = shiftLeft ? (exif.rdat2_i << shamt) : (exif.rdat2_i >> shamt);
  assign stallEx  = 1'b0;
  assign busyS    = 1'b0;
`else
  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } shState_t;

  shState_t          stateR;
  shState_t          stateN;
  logic [4:0]        cntR;
  logic [4:0]        cntN;
  logic [WORD_W-1:0] shRegR;
  logic [WORD_W-1:0] shRegN;
  logic              dirLeftR;
  logic              dirLeftN;
  logic              busyR;
  logic              shiftReq;
  logic [WORD_W-1:0] stepVal;

  assign shiftReq = exif.shift_i && (shamt != 5'd0);
  // one-bit step of the working value in the latched direction
  assign stepVal  = dirLeftR ? {shRegR[WORD_W-2:0], 1'b0} : {1'b0, shRegR[WORD_W-1:1]};

  // Shifter state register; busy is registered from the next state
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      stateR   <= S_IDLE;
      cntR     <= 5'd0;
      shRegR   <= {WORD_W{1'b0}};
      dirLeftR <= 1'b0;
      busyR    <= 1'b0;
    end else begin
      stateR   <= stateN;
      cntR     <= cntN;
      shRegR   <= shRegN;
      dirLeftR <= dirLeftN;
      busyR    <= (stateN == S_SHIFT);
    end
  end

  // Shifter next state: load on entry, step while enabled, abort on flush
  always_comb begin
    stateN   = stateR;
    cntN     = cntR;
    shRegN   = shRegR;
    dirLeftN = dirLeftR;
    case (stateR)
      S_IDLE: begin
        if (shiftReq && exif.en && !exif.flush) begin
          stateN   = S_SHIFT;
          cntN     = shamt;
          shRegN   = exif.rdat2_i;
          dirLeftN = shiftLeft;
        end else begin
          stateN   = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (exif.flush) begin
          stateN = S_IDLE;
          cntN   = 5'd0;
        end else if (exif.en) begin
          shRegN = stepVal;
          cntN   = cntR - 5'd1;
          if (cntR == 5'd1) begin
            stateN = S_IDLE;
          end else begin
            stateN = S_SHIFT;
          end
        end else begin
          stateN = S_SHIFT;
        end
      end
      default: begin
        stateN = S_IDLE;
        cntN   = 5'd0;
      end
    endcase
  end

  // Shifter outputs: the final step is presented combinationally so EX/MEM
  // captures it on the same edge the FSM returns to IDLE
  always_comb begin
    shiftOut = exif.rdat2_i;
    stallEx  = 1'b0;
    case (stateR)
      S_IDLE: begin
        shiftOut = exif.rdat2_i;
        stallEx  = shiftReq;
      end
      S_SHIFT: begin
        shiftOut = stepVal;
        stallEx  = (cntR != 5'd1);
      end
      default: begin
        shiftOut = exif.rdat2_i;
        stallEx  = 1'b0;
      end
    endcase
  end

  assign busyS = busyR;
`endif

  // Result priority: link address, then shifter, then ALU
  always_comb begin
    if (exif.jpSel_i) begin
      resultS = exif.npc_i;
    end else if (exif.shift_i) begin
      resultS = shiftOut;
    end else begin
      resultS = aluOut;
    end
  end

  // ------------------------------------------------------------------
  // Branch resolution
  // ------------------------------------------------------------------
  assign isZero    = (exif.rdat1_i == exif.rdat2_i);
  assign branchTgt = exif.npc_i + {immSext[WORD_W-3:0], 2'b00};

  // Decide taken/target from pcSrc: BEQ, BNE, JR
  always_comb begin
    takenRaw  = 1'b0;
    brTargetS = branchTgt;
    case (exif.pcSrc_i)
      2'b01:   takenRaw = isZero;
      2'b10:   takenRaw = !isZero;
      2'b11: begin
        takenRaw  = 1'b1;
        brTargetS = exif.rdat1_i;
      end
      default: takenRaw = 1'b0;
    endcase
  end

  assign exif.br_taken  = takenRaw & ~busyS & ~exif.flush;
  assign exif.br_target = brTargetS;
  assign exif.busy      = busyS;

  // ------------------------------------------------------------------
  // EX/MEM latch
  // ------------------------------------------------------------------
  always_comb begin
    exMemN.result = resultS;
    exMemN.wdat   = exif.rdat2_i;
    exMemN.npc    = exif.npc_i;
    exMemN.instr  = exif.instr_i;
    exMemN.regWr  = exif.regWr_i;
    exMemN.dWEN   = exif.dWEN_i;
    exMemN.dREN   = exif.dREN_i;
    exMemN.halt   = exif.halt_i;
    exMemN.rdSel  = exif.rdSel_i;
  end

  // EX/MEM update: reset, flush and shifter stall load bubbles; en low holds
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      exMemR <= '0;
    end else if (exif.flush) begin
      exMemR <= '0;
    end else if (exif.en && stallEx) begin
      exMemR <= '0;
    end else if (exif.en) begin
      exMemR <= exMemN;
    end else begin
      exMemR <= exMemR;
    end
  end

  assign exif.result_o = exMemR.result;
  assign exif.wdat_o   = exMemR.wdat;
  assign exif.npc_o    = exMemR.npc;
  assign exif.instr_o  = exMemR.instr;
  assign exif.regWr_o  = exMemR.regWr;
  assign exif.dWEN_o   = exMemR.dWEN;
  assign exif.dREN_o   = exMemR.dREN;
  assign exif.halt_o   = exMemR.halt;
  assign exif.rdSel_o  = exMemR.rdSel;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: randomized self-checking bench for ex_stage against an
// arithmetic reference model of the execute stage.
module tb_ex_stage;
  import cpu_types_pkg::*;

  logic clk  = 1'b0;
  logic nRST = 1'b0;
  int   checks = 0;
  int   errors = 0;

  ex_stage_if exif ();

  ex_stage #(.WORD_W(32)) dut (
    .CLK  (clk),
    .nRST (nRST),
    .exif (exif)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_imm(input logic [5:0] opc, input logic [15:0] im);
    if (opc == 6'h0C || opc == 6'h0D || opc == 6'h0E) return {16'h0000, im};
    if (opc == 6'h0F) return 32'(im) * 32'd65536;
    return 32'($signed(im));
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd2: return a + b;
      4'd3: return a - b;
      4'd4: return a & b;
      4'd5: return a | b;
      4'd6: return a ^ b;
      4'd7: return ~(a | b);
      4'd8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // repeated doubling / halving, k times
  function automatic logic [31:0] ref_shift(input bit left, input logic [31:0] v, input int k);
    logic [31:0] r;
    r = v;
    for (int i = 0; i < k; i++) r = left ? r + r : r / 32'd2;
    return r;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic clear_inputs();
    exif.instr_i = 32'd0; exif.npc_i = 32'd0; exif.rdat1_i = 32'd0; exif.rdat2_i = 32'd0;
    exif.aluOp_i = 4'd0; exif.aluSrc_i = 1'b0; exif.shift_i = 1'b0; exif.jpSel_i = 1'b0;
    exif.pcSrc_i = 2'b00; exif.regWr_i = 1'b0; exif.dWEN_i = 1'b0; exif.dREN_i = 1'b0;
    exif.halt_i = 1'b0; exif.rdSel_i = 3'd0; exif.en = 1'b1; exif.flush = 1'b0;
  endtask

  task automatic drive_alu(input logic [5:0] opc, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [15:0] im);
    logic [31:0] w;
    w = {opc, 10'($urandom), im};
    exif.instr_i = w; exif.aluOp_i = op; exif.aluSrc_i = (opc != 6'h00);
    exif.rdat1_i = a; exif.rdat2_i = b; exif.shift_i = 1'b0; exif.jpSel_i = 1'b0;
    exif.pcSrc_i = 2'b00; exif.npc_i = $urandom; exif.regWr_i = 1'b1;
  endtask

  task automatic drive_shift(input bit left, input logic [31:0] v, input int k);
    logic [31:0] w;
    w = 32'd0;
    w[10:6] = 5'(k);
    w[5:0]  = left ? 6'h00 : 6'h02;
    exif.instr_i = w; exif.aluOp_i = left ? ALU_SLL : ALU_SRL; exif.aluSrc_i = 1'b0;
    exif.rdat1_i = $urandom; exif.rdat2_i = v; exif.shift_i = 1'b1; exif.jpSel_i = 1'b0;
    exif.pcSrc_i = 2'b00; exif.npc_i = $urandom; exif.regWr_i = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    nRST = 1'b0;
    drive_shift(1'b1, 32'hDEAD_BEEF, 7);
    exif.dWEN_i = 1'b1; exif.halt_i = 1'b1; exif.rdSel_i = 3'd5;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({exif.result_o, exif.wdat_o, exif.npc_o, exif.instr_o} !== 128'd0) begin
      errors++; $display("FAIL reset_data got %h exp 0", {exif.result_o, exif.wdat_o, exif.npc_o, exif.instr_o});
    end
    checks++;
    if ({exif.regWr_o, exif.dWEN_o, exif.dREN_o, exif.halt_o, exif.rdSel_o, exif.busy} !== 8'd0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 0", {exif.regWr_o, exif.dWEN_o, exif.dREN_o, exif.halt_o, exif.rdSel_o, exif.busy});
    end
    clear_inputs();
    nRST = 1'b1;
  endtask

  task automatic test_add_slt();
    drive_alu(6'h00, ALU_ADD, 32'h7FFF_FFFF, 32'd1, 16'h0000);
    @(posedge clk); #1;
    checks++;
    if (exif.result_o !== 32'h8000_0000) begin
      errors++; $display("FAIL add_wrap got %h exp 80000000", exif.result_o);
    end
    drive_alu(6'h00, ALU_SLT, 32'h7FFF_FFFF, 32'd1, 16'h0000);
    @(posedge clk); #1;
    checks++;
    if (exif.result_o !== 32'd0) begin
      errors++; $display("FAIL slt_signed got %h exp 0", exif.result_o);
    end
  endtask

  // random back-to-back ALU traffic, one instruction per cycle
  task automatic test_alu_random();
    logic [5:0]  opcs [7] = '{6'h00, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
    logic [5:0]  opc;
    logic [3:0]  op;
    logic [31:0] a, b, ex, npc, ins;
    logic [15:0] im;
    logic [6:0]  ctl;
    bit          jp;
    for (int i = 0; i < 24; i++) begin
      opc = opcs[$urandom_range(0, 6)];
      op  = 4'($urandom_range(2, 9));
      a   = $urandom; b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      im  = 16'($urandom);
      jp  = ($urandom_range(0, 7) == 0);
      ctl = 7'($urandom);
      drive_alu(opc, op, a, b, im);
      exif.jpSel_i = jp;
      {exif.regWr_i, exif.dWEN_i, exif.dREN_i, exif.halt_i, exif.rdSel_i} = ctl;
      npc = exif.npc_i; ins = exif.instr_i;
      ex = jp ? npc : ref_alu(op, a, (opc != 6'h00) ? ref_imm(opc, im) : b);
      @(posedge clk); #1;
      checks++;
      if (exif.result_o !== ex) begin
        errors++; $display("FAIL alu_result[%0d] op %0d opc %h got %h exp %h", i, op, opc, exif.result_o, ex);
      end
      checks++;
      if ({exif.wdat_o, exif.npc_o, exif.instr_o} !== {b, npc, ins}) begin
        errors++; $display("FAIL alu_pass[%0d] got %h exp %h", i, {exif.wdat_o, exif.npc_o, exif.instr_o}, {b, npc, ins});
      end
      checks++;
      if ({exif.regWr_o, exif.dWEN_o, exif.dREN_o, exif.halt_o, exif.rdSel_o} !== ctl) begin
        errors++; $display("FAIL alu_ctrl[%0d] got %b exp %b", i, {exif.regWr_o, exif.dWEN_o, exif.dREN_o, exif.halt_o, exif.rdSel_o}, ctl);
      end
    end
  endtask

  task automatic test_branch();
    logic [31:0] a, b, npc, tgt;
    logic [15:0] im;
    logic [1:0]  ps;
    bit          tk;
    for (int i = 0; i < 20; i++) begin
      if (i == 0) begin
        a = 32'd5; b = 32'd5; npc = 32'h104; im = 16'hFFFE; ps = 2'b01;
      end else begin
        a = $urandom; b = ($urandom_range(0, 1) == 0) ? a : $urandom;
        npc = $urandom; im = 16'($urandom); ps = 2'($urandom);
      end
      drive_alu(6'h04, ALU_SUB, a, b, im);
      exif.aluSrc_i = 1'b0; exif.pcSrc_i = ps; exif.npc_i = npc;
      exif.flush = (i == 19);
      tk  = (ps == 2'b01) ? (a == b) : (ps == 2'b10) ? (a != b) : (ps == 2'b11);
      if (i == 19) tk = 1'b0;
      tgt = (ps == 2'b11) ? a : npc + 32'($signed(im)) * 32'd4;
      #1;
      checks++;
      if (exif.br_taken !== tk) begin
        errors++; $display("FAIL br_taken[%0d] pcSrc %0d got %b exp %b", i, ps, exif.br_taken, tk);
      end
      if (ps != 2'b00) begin
        checks++;
        if (exif.br_target !== tgt) begin
          errors++; $display("FAIL br_target[%0d] got %h exp %h", i, exif.br_target, tgt);
        end
      end
      @(posedge clk); #1;
    end
    exif.flush = 1'b0;
  endtask

  task automatic test_hold_flush();
    logic [31:0] a, b;
    a = $urandom; b = $urandom;
    drive_alu(6'h00, ALU_XOR, a, b, 16'h0000);
    @(posedge clk); #1;
    drive_alu(6'h00, ALU_ADD, $urandom, $urandom, 16'h0000);
    exif.en = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (exif.result_o !== (a ^ b) || exif.wdat_o !== b) begin
      errors++; $display("FAIL en_hold got %h/%h exp %h/%h", exif.result_o, exif.wdat_o, a ^ b, b);
    end
    exif.en = 1'b1; exif.flush = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (exif.result_o !== 32'd0 || exif.regWr_o !== 1'b0 || exif.npc_o !== 32'd0) begin
      errors++; $display("FAIL flush_wins got %h/%b exp 0/0", exif.result_o, exif.regWr_o);
    end
    exif.flush = 1'b0;
  endtask

  task automatic test_shift_zero();
    logic [31:0] v;
    v = $urandom;
    drive_shift(1'b1, v, 0);
    @(posedge clk); #1;
    checks++;
    if (exif.result_o !== v || exif.busy !== 1'b0) begin
      errors++; $display("FAIL shamt_zero got %h busy %b exp %h busy 0", exif.result_o, exif.busy, v);
    end
  endtask

`ifdef EX_FAST_SHIFT_EN
  task automatic test_fast_shift();
    logic [31:0] v, ex;
    int          k;
    bit          left;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) begin
        left = 1'b0; v = 32'h8000_0000; k = 31;
      end else begin
        left = $urandom_range(0, 1); v = $urandom; k = $urandom_range(1, 31);
      end
      ex = ref_shift(left, v, k);
      drive_shift(left, v, k);
      @(posedge clk); #1;
      checks++;
      if (exif.result_o !== ex || exif.busy !== 1'b0) begin
        errors++; $display("FAIL fast_shift[%0d] got %h busy %b exp %h busy 0", i, exif.result_o, exif.busy, ex);
      end
    end
  endtask
`else
  // en is dropped on busy cycles [dropAt, dropAt+dropLen)
  task automatic test_shift(input bit left, input logic [31:0] v, input int k,
                            input int dropAt, input int dropLen);
    logic [31:0] ex;
    int          rem, cyc;
    ex = ref_shift(left, v, k);
    drive_shift(left, v, k);
    @(posedge clk); #1;
    rem = k; cyc = 0;
    while (rem > 0 && cyc < 64) begin
      checks++;
      if (exif.busy !== 1'b1) begin
        errors++; $display("FAIL shift_busy k=%0d cyc %0d got %b exp 1", k, cyc, exif.busy);
      end
      checks++;
      if (exif.result_o !== 32'd0 || exif.regWr_o !== 1'b0) begin
        errors++; $display("FAIL shift_bubble k=%0d cyc %0d got %h/%b exp 0/0", k, cyc, exif.result_o, exif.regWr_o);
      end
      exif.en = !(cyc >= dropAt && cyc < dropAt + dropLen);
      @(posedge clk); #1;
      if (exif.en) rem--;
      cyc++;
    end
    exif.en = 1'b1;
    checks++;
    if (exif.busy !== 1'b0 || exif.result_o !== ex || exif.regWr_o !== 1'b1) begin
      errors++; $display("FAIL shift_done k=%0d got %h busy %b exp %h busy 0", k, exif.result_o, exif.busy, ex);
    end
  endtask

  task automatic test_shift_flush();
    logic [31:0] a, b;
    drive_shift(1'b0, $urandom, 8);
    @(posedge clk); #1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (exif.busy !== 1'b1) begin
        errors++; $display("FAIL flush_pre_busy cyc %0d got %b exp 1", c, exif.busy);
      end
      exif.flush = (c == 2);
      #1;
      if (c == 2) begin
        checks++;
        exif.pcSrc_i = 2'b11;
        #1;
        if (exif.br_taken !== 1'b0) begin
          errors++; $display("FAIL busy_gates_branch got %b exp 0", exif.br_taken);
        end
        exif.pcSrc_i = 2'b00;
      end
      @(posedge clk); #1;
    end
    exif.flush = 1'b0;
    checks++;
    if (exif.busy !== 1'b0 || exif.result_o !== 32'd0 || exif.regWr_o !== 1'b0) begin
      errors++; $display("FAIL shift_flush got %h busy %b exp 0 busy 0", exif.result_o, exif.busy);
    end
    a = $urandom; b = $urandom;
    drive_alu(6'h00, ALU_ADD, a, b, 16'h0000);
    @(posedge clk); #1;
    checks++;
    if (exif.result_o !== a + b || exif.busy !== 1'b0) begin
      errors++; $display("FAIL after_flush_add got %h exp %h", exif.result_o, a + b);
    end
  endtask

  task automatic test_reset_mid_shift();
    logic [31:0] a, b;
    drive_shift(1'b1, $urandom, 12);
    repeat (4) @(posedge clk);
    #1;
    nRST = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (exif.busy !== 1'b0 || exif.result_o !== 32'd0) begin
      errors++; $display("FAIL reset_mid_shift got busy %b res %h exp 0/0", exif.busy, exif.result_o);
    end
    nRST = 1'b1;
    a = $urandom; b = $urandom;
    drive_alu(6'h00, ALU_SUB, a, b, 16'h0000);
    @(posedge clk); #1;
    checks++;
    if (exif.result_o !== a - b) begin
      errors++; $display("FAIL after_reset_sub got %h exp %h", exif.result_o, a - b);
    end
  endtask
`endif

  initial begin
    clear_inputs();
    test_reset();
    test_add_slt();
    test_alu_random();
    test_branch();
    test_hold_flush();
    test_shift_zero();
`ifdef EX_FAST_SHIFT_EN
    test_fast_shift();
`else
    test_shift(1'b1, 32'h0000_0001, 4, 99, 0);
    test_shift(1'b1, 32'h0000_0001, 4, 1, 2);
    test_shift(1'b0, $urandom, 17, 3, 4);
    test_shift(1'b0, 32'h8000_0000, 31, 99, 0);
    test_shift_flush();
    test_reset_mid_shift();
`endif
    test_alu_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
